// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: signed/unsigned MUL and DIV with a
// start/busy/done handshake, annul, configurable multiply radix and div-by-zero flag.
module muldiv_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZDIV} state_t;
  state_t state_q, state_d;

  logic             div_q, sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;   // mul: |b| shifting right; div: dividend in, quotient out
  logic [W2-1:0]    mc_q;   // mul: |a| shifting left; div: divisor in low half
  logic [W2-1:0]    acc_q;  // mul: product; div: partial remainder in low WIDTH+1 bits
  logic [W2-1:0]    result_q;
  logic             done_q, dbz_q;

  logic             accept, zdiv_in, sa_in, sb_in, zdiv_fire;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [W2-1:0]    mul_sum, fix_val;
  logic [WIDTH:0]   div_sh, div_diff;

  always_comb begin
    accept  = (state_q == IDLE || state_q == ZDIV) && start && !annul;
    zdiv_in = op[1] && (b == '0);
    sa_in   = !op[0] && a[WIDTH-1];
    sb_in   = !op[0] && b[WIDTH-1];
    mag_a   = sa_in ? -a : a;
    mag_b   = sb_in ? -b : b;
  end

  always_comb begin
    mul_sum = acc_q;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (sh_q[i]) mul_sum = mul_sum + (mc_q << i);
    end
    div_sh   = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, mc_q[WIDTH-1:0]};
    q_fix    = (sa_q ^ sb_q) ? -sh_q : sh_q;
    r_fix    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_val  = div_q ? {r_fix, q_fix} : ((sa_q ^ sb_q) ? -acc_q : acc_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ZDIV: state_d = accept ? (zdiv_in ? ZDIV : CALC) : IDLE;
      CALC: begin
        if (annul)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ZDIV completes combinationally so that annul in that cycle can still suppress it
  assign zdiv_fire   = (state_q == ZDIV) && !annul;
  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = done_q || zdiv_fire;
  assign div_by_zero = dbz_q || zdiv_fire;
  assign result      = zdiv_fire ? {sh_q, {WIDTH{1'b1}}} : result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        div_q <= op[1];
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        cnt_q <= op[1] ? DIV_LAST : MUL_LAST;
        acc_q <= '0;
        dbz_q <= 1'b0;
        if (op[1]) begin
          // divide-by-zero keeps the raw dividend for the {a, all-ones} result
          sh_q <= zdiv_in ? a : mag_a;
          mc_q <= {{WIDTH{1'b0}}, mag_b};
        end else begin
          sh_q <= mag_b;
          mc_q <= {{WIDTH{1'b0}}, mag_a};
        end
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CW'(1);
        if (div_q) begin
          sh_q  <= {sh_q[WIDTH-2:0], !div_diff[WIDTH]};
          acc_q <= {{(WIDTH-1){1'b0}}, div_diff[WIDTH] ? div_sh : div_diff};
        end else begin
          acc_q <= mul_sum;
          mc_q  <= mc_q << MUL_STEP;
          sh_q  <= sh_q >> MUL_STEP;
        end
      end
      if (state_q == FIX && !annul) begin
        result_q <= fix_val;
        done_q   <= 1'b1;
      end
      if (zdiv_fire) begin
        result_q <= {sh_q, {WIDTH{1'b1}}};
        if (!accept) dbz_q <= 1'b1;
      end
    end
  end
endmodule
